detect_event_logger: RTL and testbench
======================================

# detect_event_logger

Downstream consumer of the Moore sequence detector's `detector_out`. Timestamps every detection against a free-running cycle counter, queues timestamps in a small show-ahead FIFO, and exposes them on a valid/ready read port. Also maintains a saturating event count and a sticky overflow flag. The read side connects to a host/readout stage.

## Interface
- `TS_WIDTH`, 16: timestamp counter width, wraps modulo 2^TS_WIDTH.
- `DEPTH`, 8: FIFO entries, power of 2, ≥2.
- `COUNT_WIDTH`, 8: event/drop counter width, saturating.
- `EDGE_MODE`, 0: 0 = every cycle `detect_in`=1 is one event; 1 = only 0→1 transitions are events.

Ports:
- `clock`  in  1  rising-edge clock, sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `detect_in`  in  1  detector output (`detector_out`), sampled each edge.
- `clear`  in  1  synchronous clear of FIFO, counters and overflow; timestamp keeps running.
- `rd_ready`  in  1  consumer accepts head entry.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_data`  out  TS_WIDTH  head timestamp; valid only when `rd_valid`=1.
- `event_count`  out  COUNT_WIDTH  events seen since reset/clear, saturating.
- `drop_count`  out  COUNT_WIDTH  events lost to full FIFO, saturating.
- `overflow`  out  1  sticky; set on first drop.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Reset (any edge with `reset`=1): `ts`=0, FIFO empty, `rd_valid`=0, `rd_data`=0, `event_count`=0, `drop_count`=0, `overflow`=0, `level`=0, edge-detect history=0. Reset overrides everything, including in-flight FIFO contents.
- Timestamp `ts`: increments by 1 every edge with `reset`=0; wraps from 2^TS_WIDTH−1 to 0. Unaffected by `clear`.
- Event: EDGE_MODE=0 → `detect_in`=1; EDGE_MODE=1 → `detect_in`=1 and previous sampled `detect_in`=0. History resets to 0, so a high first sample after reset is an event.
- On an event edge: push current `ts` (pre-increment value); `event_count`+1, saturating at all-ones.
- Push is accepted if `level`<DEPTH, or if `level`=DEPTH and a pop occurs on the same edge. Otherwise the event is dropped: `drop_count`+1 (saturating), `overflow`←1. `event_count` still increments.
- Pop: `rd_valid`&&`rd_ready` on an edge removes the head. `rd_ready` while empty has no effect.
- Simultaneous push+pop: `level` unchanged; at `level`=0 no pop occurs, so push only.
- `clear`=1: FIFO emptied, `event_count`=0, `drop_count`=0, `overflow`=0. Any event or pop on the same edge is discarded. Edge-detect history still updates.
- Pointers: log2(DEPTH)-bit read/write pointers wrap naturally. Full/empty are derived from `level`.

## Timing
- All outputs are registered or decoded from registers, with no combinational path from any input to any output.
- Event latency: event sampled at edge N → entry visible (`rd_valid`=1 if previously empty, `rd_data`=T) after edge N, i.e. 1 cycle.
- `rd_data` is show-ahead. After a pop at edge N, the next entry is presented after edge N.
- Counters and `overflow` update at the same edge as the push decision.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset: hold `reset` 2 cycles with `detect_in`=1 → after reset all outputs 0. The first edge after release pushes `ts`=0 (EDGE_MODE=0).
- Basic: EDGE_MODE=0, `rd_ready`=0, single-cycle `detect_in` pulses sampled at `ts`=3,5,7 → `level`=3, `event_count`=3. Then `rd_ready`=1 → `rd_data` reads 3,5,7 on consecutive cycles, then `rd_valid`=0.
- Edge mode: EDGE_MODE=1, `detect_in` high for `ts`=10..14 → one entry (10), `event_count`=1. EDGE_MODE=0 with the same stimulus → 5 entries (10..14).
- Full/overflow: DEPTH=8, `rd_ready`=0, 10 events → `level`=8, `event_count`=10, `drop_count`=2, `overflow`=1, FIFO holds the first 8 timestamps. On the next event with `rd_ready`=1 while full → push accepted, `level` stays 8, `drop_count` stays 2.
- Clear: with 3 entries queued, assert `clear` coinciding with an event and `rd_ready`=1 → next cycle `level`=0, all counters 0, `overflow`=0, and `ts` continues without a gap.
- Wrap: TS_WIDTH=4, event at `ts`=15 and at the next cycle → reads 15 then 0. Saturation: COUNT_WIDTH=4, 20 events → `event_count`=15.

Source files
------------

// File: rtl/detect_event_logger.sv
// detect_event_logger: timestamps detector events into a show-ahead FIFO with counters.
// Ports:
//   clock_i        rising-edge clock
//   reset_i        synchronous active-high reset
//   detect_in_i    detector output, sampled every edge
//   clear_i        empties FIFO and clears counters/overflow; timestamp keeps running
//   rd_ready_i     consumer accepts the head entry
//   rd_valid_o     FIFO non-empty
//   rd_data_o      head timestamp (0 while empty)
//   event_count_o  saturating count of events since reset/clear
//   drop_count_o   saturating count of events lost to a full FIFO
//   overflow_o     sticky, set on the first drop
//   level_o        FIFO occupancy
module detect_event_logger #(
    parameter int TS_WIDTH    = 16,
    parameter int DEPTH       = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int EDGE_MODE   = 0
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       detect_in_i,
    input  logic                       clear_i,
    input  logic                       rd_ready_i,
    output logic                       rd_valid_o,
    output logic [TS_WIDTH-1:0]        rd_data_o,
    output logic [COUNT_WIDTH-1:0]     event_count_o,
    output logic [COUNT_WIDTH-1:0]     drop_count_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [TS_WIDTH-1:0]    mem [DEPTH];
    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [COUNT_WIDTH-1:0] ev_q, ev_d, drop_q, drop_d;
    logic                   ovf_q, ovf_d, prev_q, prev_d;
    logic                   evt, pop, full, push, drop;

    always_comb begin
        evt     = detect_in_i && (EDGE_MODE == 0 || !prev_q);
        pop     = (level_q != '0) && rd_ready_i;
        full    = level_q == LW'(DEPTH);
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push    = evt && (!full || pop);
        drop    = evt && !push;
        ts_d    = ts_q + 1'b1;
        prev_d  = detect_in_i;
        wptr_d  = clear_i ? '0 : wptr_q + PW'(push);
        rptr_d  = clear_i ? '0 : rptr_q + PW'(pop);
        level_d = clear_i ? '0 : level_q + LW'(push) - LW'(pop);
        ev_d    = clear_i ? '0 : ev_q + COUNT_WIDTH'(evt && ev_q != '1);
        drop_d  = clear_i ? '0 : drop_q + COUNT_WIDTH'(drop && drop_q != '1);
        ovf_d   = !clear_i && (ovf_q || drop);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ts_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ev_q    <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            ts_q    <= ts_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ev_q    <= ev_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            prev_q  <= prev_d;
            if (push && !clear_i) mem[wptr_q] <= ts_q;
        end
    end

    assign rd_valid_o    = level_q != '0;
    assign rd_data_o     = rd_valid_o ? mem[rptr_q] : '0;
    assign event_count_o = ev_q;
    assign drop_count_o  = drop_q;
    assign overflow_o    = ovf_q;
    assign level_o       = level_q;
endmodule

// File: tb/tb_detect_event_logger.sv
// tb_detect_event_logger: three configurations driven in lockstep, checked against a queue-based model.
module tb_detect_event_logger;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, d, clr, rdy;
    logic        rv_a, rv_b, rv_c, ov_a, ov_b, ov_c;
    logic [15:0] rd_a, rd_b;
    logic [3:0]  rd_c;
    logic [3:0]  lv_a, lv_b;
    logic [2:0]  lv_c;
    logic [7:0]  ec_a, ec_b, dc_a, dc_b;
    logic [3:0]  ec_c, dc_c;

    detect_event_logger #(.TS_WIDTH(16), .DEPTH(8), .COUNT_WIDTH(8), .EDGE_MODE(0)) u_a (
        .clock_i(clk), .reset_i(rst), .detect_in_i(d), .clear_i(clr), .rd_ready_i(rdy),
        .rd_valid_o(rv_a), .rd_data_o(rd_a), .event_count_o(ec_a), .drop_count_o(dc_a),
        .overflow_o(ov_a), .level_o(lv_a));
    detect_event_logger #(.TS_WIDTH(16), .DEPTH(8), .COUNT_WIDTH(8), .EDGE_MODE(1)) u_b (
        .clock_i(clk), .reset_i(rst), .detect_in_i(d), .clear_i(clr), .rd_ready_i(rdy),
        .rd_valid_o(rv_b), .rd_data_o(rd_b), .event_count_o(ec_b), .drop_count_o(dc_b),
        .overflow_o(ov_b), .level_o(lv_b));
    detect_event_logger #(.TS_WIDTH(4), .DEPTH(4), .COUNT_WIDTH(4), .EDGE_MODE(0)) u_c (
        .clock_i(clk), .reset_i(rst), .detect_in_i(d), .clear_i(clr), .rd_ready_i(rdy),
        .rd_valid_o(rv_c), .rd_data_o(rd_c), .event_count_o(ec_c), .drop_count_o(dc_c),
        .overflow_o(ov_c), .level_o(lv_c));

    int tsw[3] = '{16, 16, 4};
    int dep[3] = '{8, 8, 4};
    int cwm[3] = '{8, 8, 4};
    int em[3]  = '{0, 1, 0};
    int mts[3], mn[3], mev[3], mdr[3], mov[3], mprev[3];
    int mq[3][8];
    int vectors = 0, miscompares = 0;
    bit chk = 0;

    task automatic check(string name, logic [31:0] act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mts[k] = 0; mn[k] = 0; mev[k] = 0; mdr[k] = 0; mov[k] = 0; mprev[k] = 0;
            end else begin
                int maxc = (1 << cwm[k]) - 1;
                bit ev = d && (em[k] == 0 || mprev[k] == 0);
                bit pop = mn[k] > 0 && rdy;
                if (clr) begin
                    mn[k] = 0; mev[k] = 0; mdr[k] = 0; mov[k] = 0;
                end else begin
                    if (pop) begin
                        for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
                        mn[k]--;
                    end
                    if (ev) begin
                        if (mev[k] < maxc) mev[k]++;
                        if (mn[k] < dep[k]) begin
                            mq[k][mn[k]] = mts[k];
                            mn[k]++;
                        end else begin
                            if (mdr[k] < maxc) mdr[k]++;
                            mov[k] = 1;
                        end
                    end
                end
                mprev[k] = d;
                mts[k] = (mts[k] + 1) % (1 << tsw[k]);
            end
        end
    endtask

    task automatic cmp(int k, logic v, logic [15:0] rdd, logic [3:0] l, logic [7:0] e, logic [7:0] dr, logic o);
        string p = (k == 0) ? "A" : (k == 1) ? "B" : "C";
        check({p, " rd_valid"}, 32'(v), mn[k] > 0);
        if (mn[k] > 0) check({p, " rd_data"}, 32'(rdd), mq[k][0]);
        check({p, " level"}, 32'(l), mn[k]);
        check({p, " event_count"}, 32'(e), mev[k]);
        check({p, " drop_count"}, 32'(dr), mdr[k]);
        check({p, " overflow"}, 32'(o), mov[k]);
    endtask

    task automatic cyc(bit r, bit dd, bit c, bit y);
        rst = r; d = dd; clr = c; rdy = y;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk) begin
            cmp(0, rv_a, rd_a, lv_a, ec_a, dc_a, ov_a);
            cmp(1, rv_b, rd_b, lv_b, ec_b, dc_b, ov_b);
            cmp(2, rv_c, 16'(rd_c), 4'(lv_c), 8'(ec_c), 8'(dc_c), ov_c);
        end
    endtask

    initial begin
        cyc(1, 1, 0, 0);
        chk = 1;
        cyc(1, 1, 0, 0);
        check("reset rd_valid", 32'(rv_a), 0);
        check("reset rd_data", 32'(rd_a), 0);
        check("reset level", 32'(lv_a), 0);
        check("reset event_count", 32'(ec_a), 0);
        cyc(0, 1, 0, 0);
        check("first push data", 32'(rd_a), 0);
        check("first push level", 32'(lv_a), 1);

        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, i == 3 || i == 5 || i == 7, 0, 0);
        check("basic level", 32'(lv_a), 3);
        check("basic count", 32'(ec_a), 3);
        check("basic read0", 32'(rd_a), 3);
        cyc(0, 0, 0, 1);
        check("basic read1", 32'(rd_a), 5);
        cyc(0, 0, 0, 1);
        check("basic read2", 32'(rd_a), 7);
        cyc(0, 0, 0, 1);
        check("basic drained", 32'(rv_a), 0);

        cyc(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, i >= 10 && i <= 14, 0, 0);
        check("level mode level", 32'(lv_a), 5);
        check("level mode head", 32'(rd_a), 10);
        check("edge mode level", 32'(lv_b), 1);
        check("edge mode count", 32'(ec_b), 1);
        check("edge mode head", 32'(rd_b), 10);

        cyc(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        check("full level", 32'(lv_a), 8);
        check("full event_count", 32'(ec_a), 10);
        check("full drop_count", 32'(dc_a), 2);
        check("full overflow", 32'(ov_a), 1);
        check("full head", 32'(rd_a), 0);
        cyc(0, 1, 0, 1);
        check("full push+pop level", 32'(lv_a), 8);
        check("full push+pop drops", 32'(dc_a), 2);
        check("full push+pop head", 32'(rd_a), 1);

        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, i % 2 == 0, 0, 0);
        check("pre-clear level", 32'(lv_a), 3);
        cyc(0, 1, 1, 1);
        check("clear level", 32'(lv_a), 0);
        check("clear event_count", 32'(ec_a), 0);
        check("clear overflow", 32'(ov_a), 0);
        cyc(0, 1, 0, 0);
        check("post-clear ts", 32'(rd_a), 6);

        cyc(1, 0, 0, 0);
        for (int i = 0; i < 17; i++) cyc(0, i >= 15, 0, 0);
        check("wrap level", 32'(lv_c), 2);
        check("wrap read0", 32'(rd_c), 15);
        cyc(0, 0, 0, 1);
        check("wrap read1", 32'(rd_c), 0);

        cyc(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);
        check("sat event_count", 32'(ec_c), 15);
        check("sat drop_count", 32'(dc_c), 15);
        check("wide event_count", 32'(ec_a), 20);

        for (int blk = 0; blk < 6; blk++) begin
            int p = (blk % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 500; i++)
                cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60,
                    $urandom_range(0, 99) == 0, $urandom_range(0, 99) < p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
